// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB stage driving the register-file write port, with load wait and sub-word extraction
module writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      InRegWrite,
  input  logic                      InMemToReg,
  input  logic [REG_ADDR_WIDTH-1:0] InWriteRegister,
  input  logic [DATA_WIDTH-1:0]     InAluResult,
  input  logic [1:0]                InLoadSize,
  input  logic                      InLoadSigned,
  input  logic [DATA_WIDTH-1:0]     MemReadData,
  input  logic                      MemReady,
  input  logic                      Flush,
  output logic [REG_ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0]     WriteData,
  output logic                      RegWrite,
  output logic                      PendingLoad,
  output logic [REG_ADDR_WIDTH-1:0] PendingRegister,
  output logic [COUNT_WIDTH-1:0]    RetireCount
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_MEM = 2'd1, WRITE = 2'd2;
  logic [1:0] state;
  logic       pendRegWrite, pendSigned;
  logic [1:0] pendSize, pendOffset;
  logic       accept, inDirect, memDone;
  logic       retire, retireWrite;
  logic [REG_ADDR_WIDTH-1:0] retireReg;
  logic [DATA_WIDTH-1:0]     retireData;

  function automatic logic [DATA_WIDTH-1:0] extract(
    input logic [DATA_WIDTH-1:0] data,
    input logic [1:0]            size,
    input logic                  sgn,
    input logic [1:0]            off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = data[{off[1], 4'b0000} +: 16];
    extract = size == 2'd0 ? {{(DATA_WIDTH-8){sgn & b[7]}}, b} :
              size == 2'd1 ? {{(DATA_WIDTH-16){sgn & h[15]}}, h} : data;
  endfunction

  assign InReady     = state != WAIT_MEM;
  assign PendingLoad = state == WAIT_MEM;
  assign accept      = InValid & InReady & ~Flush;
  assign inDirect    = accept & (~InMemToReg | MemReady);
  assign memDone     = (state == WAIT_MEM) & ~Flush & MemReady;

  always_comb begin
    retire      = inDirect | memDone;
    retireWrite = memDone ? pendRegWrite : InRegWrite;
    retireReg   = memDone ? PendingRegister : InWriteRegister;
    retireData  = memDone ? extract(MemReadData, pendSize, pendSigned, pendOffset) :
                  InMemToReg ? extract(MemReadData, InLoadSize, InLoadSigned, InAluResult[1:0]) :
                  InAluResult;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      RegWrite        <= 1'b0;
      WriteRegister   <= '0;
      WriteData       <= '0;
      PendingRegister <= '0;
      pendRegWrite    <= 1'b0;
      pendSigned      <= 1'b0;
      pendSize        <= 2'd0;
      pendOffset      <= 2'd0;
      RetireCount     <= '0;
    end else begin
      RegWrite <= retire & retireWrite & (retireReg != '0);
      // Outputs only move on a real write so the bypass source stays stable otherwise
      if (retire & retireWrite & (retireReg != '0)) begin
        WriteRegister <= retireReg;
        WriteData     <= retireData;
      end
      if (retire) RetireCount <= RetireCount + COUNT_WIDTH'(1);
      if (accept & InMemToReg & ~MemReady) begin
        PendingRegister <= InWriteRegister;
        pendRegWrite    <= InRegWrite;
        pendSigned      <= InLoadSigned;
        pendSize        <= InLoadSize;
        pendOffset      <= InAluResult[1:0];
      end
      if (state == WAIT_MEM)
        state <= Flush ? IDLE : MemReady ? WRITE : WAIT_MEM;
      else
        state <= inDirect ? WRITE : accept ? WAIT_MEM : IDLE;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed plan plus random stimulus against a behavioural retire model
module tb_writeback_stage;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0, InRegWrite = 1'b0, InMemToReg = 1'b0, InLoadSigned = 1'b0;
  logic [4:0]  InWriteRegister = '0;
  logic [31:0] InAluResult = '0, MemReadData = '0;
  logic [1:0]  InLoadSize = '0;
  logic        MemReady = 1'b0, Flush = 1'b0;
  logic        InReady, RegWrite, PendingLoad;
  logic [4:0]  WriteRegister, PendingRegister;
  logic [31:0] WriteData, RetireCount;
  int checks = 0, errors = 0;

  writeback_stage dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegWrite(InRegWrite), .InMemToReg(InMemToReg), .InWriteRegister(InWriteRegister),
    .InAluResult(InAluResult), .InLoadSize(InLoadSize), .InLoadSigned(InLoadSigned),
    .MemReadData(MemReadData), .MemReady(MemReady), .Flush(Flush),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .PendingLoad(PendingLoad), .PendingRegister(PendingRegister), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  // model state: one optional waiting load plus the last observable write
  bit          mWait, mWrite;
  logic [4:0]  mReg, pReg;
  logic [31:0] mData, mCount;
  bit          pRw, pSg;
  logic [1:0]  pSz, pOff;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] loadValue(input logic [31:0] d, input logic [1:0] sz,
                                            input bit sg, input logic [1:0] off);
    logic [31:0] v;
    int bits;
    if (sz == 2'd0) begin v = (d >> (8 * off)) & 32'hFF; bits = 8; end
    else if (sz == 2'd1) begin v = (d >> (off[1] ? 16 : 0)) & 32'hFFFF; bits = 16; end
    else return d;
    if (sg && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  task automatic retire(input bit rw, input logic [4:0] r, input logic [31:0] d);
    mCount++;
    if (rw && r != 0) begin mWrite = 1; mReg = r; mData = d; end
  endtask

  task automatic modelStep();
    mWrite = 0;
    if (Reset) begin
      mWait = 0; mReg = 0; mData = 0; mCount = 0; pReg = 0;
    end else if (mWait) begin
      if (Flush) mWait = 0;
      else if (MemReady) begin
        mWait = 0;
        retire(pRw, pReg, loadValue(MemReadData, pSz, pSg, pOff));
      end
    end else if (InValid && !Flush) begin
      if (InMemToReg && !MemReady) begin
        mWait = 1; pReg = InWriteRegister; pRw = InRegWrite;
        pSz = InLoadSize; pSg = InLoadSigned; pOff = InAluResult[1:0];
      end else
        retire(InRegWrite, InWriteRegister,
               InMemToReg ? loadValue(MemReadData, InLoadSize, InLoadSigned, InAluResult[1:0]) : InAluResult);
    end
  endtask

  task automatic step();
    modelStep();
    @(negedge Clk);
    check("RegWrite", {31'd0, RegWrite}, {31'd0, mWrite});
    check("WriteRegister", {27'd0, WriteRegister}, {27'd0, mReg});
    check("WriteData", WriteData, mData);
    check("RetireCount", RetireCount, mCount);
    check("PendingLoad", {31'd0, PendingLoad}, {31'd0, mWait});
    check("InReady", {31'd0, InReady}, {31'd0, !mWait});
    if (mWait) check("PendingRegister", {27'd0, PendingRegister}, {27'd0, pReg});
  endtask

  task automatic drive(input bit v, input bit rw, input bit mtr, input logic [4:0] r,
                       input logic [31:0] a, input logic [1:0] sz, input bit sg,
                       input logic [31:0] md, input bit mr, input bit fl);
    InValid = v; InRegWrite = rw; InMemToReg = mtr; InWriteRegister = r; InAluResult = a;
    InLoadSize = sz; InLoadSigned = sg; MemReadData = md; MemReady = mr; Flush = fl;
  endtask

  initial begin
    @(negedge Clk);
    Reset = 1; step(); step();
    Reset = 0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("reset_count", RetireCount, 32'd0);
    check("reset_ready", {31'd0, InReady}, 32'd1);
    // ALU op then three back-to-back
    drive(1, 1, 0, 8, 32'h2A, 0, 0, 0, 0, 0); step();
    check("alu_we", {31'd0, RegWrite}, 32'd1);
    check("alu_data", WriteData, 32'h2A);
    check("alu_count", RetireCount, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, 5'(i), 32'(100 + i), 0, 0, 0, 0, 0); step();
      check("b2b_we", {31'd0, RegWrite}, 32'd1);
    end
    check("b2b_count", RetireCount, 32'd4);
    // lb signed with three wait cycles
    drive(1, 1, 1, 9, 32'h1003, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    check("lb_pending", {31'd0, PendingLoad}, 32'd1);
    check("lb_preg", {27'd0, PendingRegister}, 32'd9);
    check("lb_ready", {31'd0, InReady}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h80FF7F01, 1, 0); step();
    check("lb_we", {31'd0, RegWrite}, 32'd1);
    check("lb_data", WriteData, 32'hFFFFFF80);
    // lhu offset 2, data ready at accept
    drive(1, 1, 1, 10, 32'h2002, 1, 0, 32'hBEEF1234, 1, 0); step();
    check("lhu_data", WriteData, 32'h0000BEEF);
    check("lhu_nowait", {31'd0, PendingLoad}, 32'd0);
    // write to $0
    drive(1, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0); step();
    check("r0_we", {31'd0, RegWrite}, 32'd0);
    check("r0_count", RetireCount, 32'd7);
    // flush in WAIT_MEM beats MemReady
    drive(1, 1, 1, 11, 32'h0, 2, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1, 1); step();
    check("flush_we", {31'd0, RegWrite}, 32'd0);
    check("flush_pending", {31'd0, PendingLoad}, 32'd0);
    check("flush_count", RetireCount, 32'd7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // reset mid-WAIT_MEM
    drive(1, 1, 1, 12, 32'h0, 2, 0, 0, 0, 0); step();
    Reset = 1; drive(0, 0, 0, 0, 0, 0, 0, 32'hFFFF, 1, 0); step();
    Reset = 0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("rst_count", RetireCount, 32'd0);
    check("rst_pending", {31'd0, PendingLoad}, 32'd0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1),
            $urandom, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
